// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering lw/lb/lh/sw/sb/sh requests with a fixed
// number of wait states, big-endian lane selection and misalignment reporting.
module data_mem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemoryRead,
  input  logic        MemoryWrite,
  input  logic [5:0]  Opcode,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Busy,
  output logic        Error
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam logic [3:0]  CntInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [5:0]          op_q, op_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic                dual_err_q, dual_err_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [31:0]         mem [Depth];

  logic                size_word, size_half, size_byte;
  logic                acc_err;
  logic [ADDR_W-1:0]   word_idx;
  logic [31:0]         rd_word, load_val, wr_word;
  logic [7:0]          byte_lane;
  logic [15:0]         half_lane;
  logic                mem_we;

  // Upper address bits only alias onto the same word.
  logic unused_addr;
  assign unused_addr = ^Address[31:ADDR_W+2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    dual_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MemoryRead ^ MemoryWrite) begin
          op_d    = Opcode;
          addr_d  = Address[ADDR_W+1:0];
          wdata_d = WriteData;
          wr_d    = MemoryWrite;
          if (LATENCY == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end else if (MemoryRead && MemoryWrite) begin
          dual_err_d = 1'b1;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      op_q       <= 6'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      wr_q       <= 1'b0;
      dual_err_q <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      dual_err_q <= dual_err_d;
      rdata_q    <= rdata_d;
    end
  end

  // Access size decode; loads and stores of the same width share a size.
  always_comb begin
    size_word = 1'b0;
    size_half = 1'b0;
    size_byte = 1'b0;
    unique case (op_q)
      6'b100011, 6'b101011: size_word = 1'b1;
      6'b100001, 6'b101001: size_half = 1'b1;
      6'b100000, 6'b101000: size_byte = 1'b1;
      default: ;
    endcase
  end

  assign acc_err = !(size_word || size_half || size_byte)
                 || (size_word && (addr_q[1:0] != 2'd0))
                 || (size_half && addr_q[0]);

  assign word_idx = addr_q[ADDR_W+1:2];
  assign rd_word  = mem[word_idx];

  always_comb begin
    unique case (addr_q[1:0])
      2'd0:    byte_lane = rd_word[31:24];
      2'd1:    byte_lane = rd_word[23:16];
      2'd2:    byte_lane = rd_word[15:8];
      default: byte_lane = rd_word[7:0];
    endcase
  end

  assign half_lane = addr_q[1] ? rd_word[15:0] : rd_word[31:16];

  always_comb begin
    if (size_word) begin
      load_val = rd_word;
    end else if (size_half) begin
      load_val = {{16{half_lane[15]}}, half_lane};
    end else begin
      load_val = {{24{byte_lane[7]}}, byte_lane};
    end
  end

  // Sub-word stores merge into the current word so untouched lanes survive.
  always_comb begin
    wr_word = rd_word;
    if (size_word) begin
      wr_word = wdata_q;
    end else if (size_half) begin
      if (addr_q[1]) wr_word[15:0]  = wdata_q[15:0];
      else           wr_word[31:16] = wdata_q[15:0];
    end else begin
      unique case (addr_q[1:0])
        2'd0:    wr_word[31:24] = wdata_q[7:0];
        2'd1:    wr_word[23:16] = wdata_q[7:0];
        2'd2:    wr_word[15:8]  = wdata_q[7:0];
        default: wr_word[7:0]   = wdata_q[7:0];
      endcase
    end
  end

  assign mem_we = (state_q == StResp) && wr_q && !acc_err;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[word_idx] <= wr_word;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (state_q == StResp) begin
      if (acc_err) begin
        rdata_d = 32'd0;
      end else if (!wr_q) begin
        rdata_d = load_val;
      end
    end
  end

  assign ReadData = rdata_d;
  assign Ready    = (state_q == StResp);
  assign Busy     = (state_q != StIdle);
  assign Error    = ((state_q == StResp) && acc_err) || dual_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder at LATENCY=2 and LATENCY=0, checked
// against an array-based memory model with byte-lane arithmetic.
module tb_data_mem_responder;

  localparam logic [5:0] OpLw = 6'b100011, OpLb = 6'b100000, OpLh = 6'b100001;
  localparam logic [5:0] OpSw = 6'b101011, OpSb = 6'b101000, OpSh = 6'b101001;
  localparam logic [5:0] OpBad = 6'b100100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mr = 1'b0, mw = 1'b0;
  logic [5:0]  op = 6'd0;
  logic [31:0] addr = 32'd0, wd = 32'd0;
  bit          sel = 1'b0;  // 0: LATENCY=2 instance, 1: LATENCY=0 instance

  logic [31:0] rd2, rd0;
  logic        rdy2, rdy0, bsy2, bsy0, err2, err0;
  logic [31:0] rdata;
  logic        rdy, bsy, err;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [31:0] mdl_mem [2][256];
  logic [31:0] mdl_rd [2];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(8), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .MemoryRead(mr & ~sel), .MemoryWrite(mw & ~sel), .Opcode(op),
    .Address(addr), .WriteData(wd), .ReadData(rd2), .Ready(rdy2), .Busy(bsy2), .Error(err2)
  );

  data_mem_responder #(.ADDR_W(8), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .MemoryRead(mr & sel), .MemoryWrite(mw & sel), .Opcode(op),
    .Address(addr), .WriteData(wd), .ReadData(rd0), .Ready(rdy0), .Busy(bsy0), .Error(err0)
  );

  assign rdata = sel ? rd0 : rd2;
  assign rdy   = sel ? rdy0 : rdy2;
  assign bsy   = sel ? bsy0 : bsy2;
  assign err   = sel ? err0 : err2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned op_size(input logic [5:0] o);
    case (o)
      OpLw, OpSw: return 4;
      OpLh, OpSh: return 2;
      OpLb, OpSb: return 1;
      default:    return 0;
    endcase
  endfunction

  // One accepted access: model the result, drive it, then check every cycle to Ready.
  task automatic access(input bit rd, input bit wr, input logic [5:0] o,
                        input logic [31:0] a, input logic [31:0] d);
    int          s   = sel ? 1 : 0;
    int unsigned lat = sel ? 0 : 2;
    int unsigned sz  = op_size(o);
    int unsigned off = a[1:0];
    int unsigned idx = a[9:2];
    int unsigned sh;
    bit          e;
    logic [31:0] mask, lane, w, exp_rd;
    e      = (sz == 0) ? 1'b1 : ((off % sz) != 0);
    exp_rd = e ? 32'd0 : mdl_rd[s];
    if (!e) begin
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (sz * 8)) - 32'd1);
      sh   = (4 - off - sz) * 8;
      w    = mdl_mem[s][idx];
      if (wr) begin
        mdl_mem[s][idx] = (w & ~(mask << sh)) | ((d & mask) << sh);
      end else begin
        lane = (w >> sh) & mask;
        if (sz < 4 && lane[sz*8-1]) lane = lane | ~mask;
        exp_rd = lane;
      end
    end
    mdl_rd[s] = exp_rd;

    @(negedge clk);
    mr = rd; mw = wr; op = o; addr = a; wd = d;
    @(posedge clk);
    #1 mr = 1'b0; mw = 1'b0;
    for (int k = 1; k <= int'(lat) + 1; k++) begin
      @(negedge clk);
      check("busy", 32'(bsy), 32'd1);
      if (k <= int'(lat)) begin
        check("ready_early", 32'(rdy), 32'd0);
      end else begin
        check("ready", 32'(rdy), 32'd1);
        check("error", 32'(err), 32'(e));
        check("rdata", rdata, exp_rd);
      end
    end
  endtask

  task automatic dual_req();
    @(negedge clk);
    mr = 1'b1; mw = 1'b1; op = OpLw; addr = $urandom;
    @(posedge clk);
    #1 mr = 1'b0; mw = 1'b0;
    @(negedge clk);
    check("dual_flags", {29'd0, err, rdy, bsy}, 32'b100);
    check("dual_rdata", rdata, mdl_rd[sel ? 1 : 0]);
    @(negedge clk);
    check("dual_err_clear", 32'(err), 32'd0);
  endtask

  task automatic random_phase(input int n);
    logic [5:0]  o;
    logic [31:0] a;
    int          r;
    bit          wr;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0) begin
        dual_req();
      end else begin
        case ($urandom_range(0, 6))
          0: o = OpLw; 1: o = OpLb; 2: o = OpLh;
          3: o = OpSw; 4: o = OpSb; 5: o = OpSh;
          default: o = OpBad;
        endcase
        wr = (o == OpBad) ? 1'($urandom_range(0, 1)) : o[3];
        a = $urandom;
        a[9:2] = 8'($urandom_range(0, 7));
        access(!wr, wr, o, a, $urandom);
      end
    end
  endtask

  task automatic init_words();
    for (int i = 0; i < 8; i++) begin
      access(1'b0, 1'b1, OpSw, 32'(i * 4), $urandom);
    end
  endtask

  initial begin
    logic [31:0] prior;
    repeat (3) @(negedge clk);
    sel = 1'b0;
    check("reset_rdata2", rdata, 32'd0);
    check("reset_flags2", {29'd0, err, rdy, bsy}, 32'd0);
    sel = 1'b1;
    #1 check("reset_rdata0", rdata, 32'd0);
    check("reset_flags0", {29'd0, err, rdy, bsy}, 32'd0);
    mdl_rd[0] = 32'd0;
    mdl_rd[1] = 32'd0;
    rst = 1'b1;

    // LATENCY=2 directed scenarios
    sel = 1'b0;
    init_words();
    access(1'b0, 1'b1, OpSw, 32'h10, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, OpLw, 32'h10, 32'd0);
    check("lw_0x10", rdata, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, OpLb, 32'h11, 32'd0);
    check("lb_0x11", rdata, 32'hFFFF_FFAD);
    access(1'b1, 1'b0, OpLh, 32'h12, 32'd0);
    check("lh_0x12", rdata, 32'hFFFF_BEEF);
    access(1'b0, 1'b1, OpSb, 32'h13, 32'h0000_005A);
    access(1'b1, 1'b0, OpLw, 32'h10, 32'd0);
    check("lw_after_sb", rdata, 32'hDEAD_BE5A);
    access(1'b0, 1'b1, OpSw, 32'h400, 32'h1234_5678);
    access(1'b1, 1'b0, OpLw, 32'h0, 32'd0);
    check("alias_0x400", rdata, 32'h1234_5678);
    access(1'b1, 1'b0, OpLw, 32'h02, 32'd0);
    check("misaligned_lw", rdata, 32'd0);
    access(1'b0, 1'b1, OpSh, 32'h01, 32'h0000_ABCD);
    access(1'b1, 1'b0, OpLw, 32'h0, 32'd0);
    check("word0_kept", rdata, 32'h1234_5678);
    dual_req();

    // Reset during the wait states of a store drops the store.
    prior = mdl_mem[0][7];
    @(negedge clk);
    mw = 1'b1; op = OpSw; addr = 32'h1C; wd = ~prior;
    @(posedge clk);
    #1 mw = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_mid_rdata", rdata, 32'd0);
    check("rst_mid_flags", {29'd0, err, rdy, bsy}, 32'd0);
    mdl_rd[0] = 32'd0;
    mdl_rd[1] = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    access(1'b1, 1'b0, OpLw, 32'h1C, 32'd0);
    check("rst_word_kept", rdata, prior);
    random_phase(150);

    // LATENCY=0: held MemoryRead gives Ready every other cycle.
    sel = 1'b1;
    init_words();
    access(1'b1, 1'b0, OpLw, 32'h08, 32'd0);
    @(negedge clk);
    mr = 1'b1; op = OpLw; addr = 32'h08;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 6) mr = 1'b0;
      check("b2b_ready", 32'(rdy), 32'(k % 2));
      if (k % 2 == 1) check("b2b_rdata", rdata, mdl_mem[1][2]);
    end
    mdl_rd[1] = mdl_mem[1][2];
    random_phase(150);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
